// File: rtl/kern_th_edge.sv
// Thresholded 4-neighbour edge detector: flags |right-left| and |down-up| against THRESH, one-cycle latency.
// Optional macro KERN_TH_EDGE_SIGN_EN adds registered gradient sign outputs sgnx/sgny.
module kern_th_edge #(
   parameter int unsigned THRESH = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [31:0] block_in,
   output logic        valid_out,
   output logic        thdx,
   output logic        thdy
`ifdef KERN_TH_EDGE_SIGN_EN
   ,
   output logic        sgnx,
   output logic        sgny
`endif
);

   logic signed [8:0] dx_p0;
   logic signed [8:0] dy_p0;
   logic              thdx_p1;
   logic              thdy_p1;
   logic              sgnx_p1;
   logic              sgny_p1;
   logic              vld_p1;

   // |d| of a 9-bit signed gradient; -256 cannot occur, so the magnitude always fits in 9 bits
   function automatic logic [8:0] abs_grad(input logic signed [8:0] d);
      logic signed [8:0] neg;
      neg = -d;
      return d[8] ? neg : d;
   endfunction

   function automatic logic over_thresh(input logic signed [8:0] d);
      return abs_grad(d) >= 9'(THRESH);
   endfunction

   // stage p0: widen to 9 bits before subtracting so nothing wraps
   assign dx_p0 = $signed({1'b0, block_in[23:16]}) - $signed({1'b0, block_in[7:0]});
   assign dy_p0 = $signed({1'b0, block_in[15:8]})  - $signed({1'b0, block_in[31:24]});

   // stage p1: flag registers hold while no valid sample arrives
   always_ff @(posedge clock) begin
      if (reset) begin
         vld_p1  <= 1'b0;
         thdx_p1 <= 1'b0;
         thdy_p1 <= 1'b0;
         sgnx_p1 <= 1'b0;
         sgny_p1 <= 1'b0;
      end else begin
         vld_p1 <= valid_in;
         if (valid_in) begin
            thdx_p1 <= over_thresh(dx_p0);
            thdy_p1 <= over_thresh(dy_p0);
            sgnx_p1 <= dx_p0[8];
            sgny_p1 <= dy_p0[8];
         end
      end
   end

   assign valid_out = vld_p1;
   assign thdx      = thdx_p1;
   assign thdy      = thdy_p1;
`ifdef KERN_TH_EDGE_SIGN_EN
   assign sgnx      = sgnx_p1;
   assign sgny      = sgny_p1;
`else
   logic unused_sgn;
   assign unused_sgn = sgnx_p1 ^ sgny_p1;
`endif

endmodule

// File: tb/tb_kern_th_edge.sv
// Directed bench for kern_th_edge at THRESH=32; sign outputs are checked when KERN_TH_EDGE_SIGN_EN is defined.
module tb_kern_th_edge;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        valid_in = 1'b0;
   logic [31:0] block_in = 32'h0;
   logic        valid_out;
   logic        thdx;
   logic        thdy;
   int          total = 0;
   int          bad = 0;

`ifdef KERN_TH_EDGE_SIGN_EN
   localparam int OW = 5;
   logic sgnx;
   logic sgny;
   logic [OW-1:0] obs;
   assign obs = {valid_out, thdx, thdy, sgnx, sgny};
`else
   localparam int OW = 3;
   logic [OW-1:0] obs;
   assign obs = {valid_out, thdx, thdy};
`endif

   always #5 clock = ~clock;

   kern_th_edge #(.THRESH(32)) dut (
      .clock    (clock),
      .reset    (reset),
      .valid_in (valid_in),
      .block_in (block_in),
      .valid_out(valid_out),
      .thdx     (thdx),
      .thdy     (thdy)
`ifdef KERN_TH_EDGE_SIGN_EN
      ,
      .sgnx     (sgnx),
      .sgny     (sgny)
`endif
   );

   function automatic logic [OW-1:0] expv(input logic v, input logic x, input logic y,
                                         input logic sx, input logic sy);
`ifdef KERN_TH_EDGE_SIGN_EN
      return {v, x, y, sx, sy};
`else
      logic unused;
      unused = sx ^ sy;
      return {v, x, y};
`endif
   endfunction

   function automatic logic [31:0] pack(input int up, input int right, input int down, input int left);
      return {8'(up), 8'(right), 8'(down), 8'(left)};
   endfunction

   task automatic apply(input logic [31:0] blk, input logic v, input logic r);
      @(negedge clock);
      block_in = blk;
      valid_in = v;
      reset    = r;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      apply(pack(255, 255, 0, 0), 1'b1, 1'b1);
      apply(pack(255, 255, 0, 0), 1'b1, 1'b1);
      total++;
      if (obs !== expv(0, 0, 0, 0, 0)) begin
         bad++;
         $display("FAIL reset_state got=%b exp=%b", obs, expv(0, 0, 0, 0, 0));
      end
   endtask

   task automatic test_small();
      for (int i = 6; i <= 10; i++) begin
         apply(pack(0, 0, i, i), 1'b1, 1'b0);
         total++;
         if (obs !== expv(1, 0, 0, 1, 0)) begin
            bad++;
            $display("FAIL small_grad i=%0d got=%b exp=%b", i, obs, expv(1, 0, 0, 1, 0));
         end
      end
   endtask

   task automatic test_flat();
      apply(32'h0, 1'b1, 1'b0);
      total++;
      if (obs !== expv(1, 0, 0, 0, 0)) begin
         bad++;
         $display("FAIL flat got=%b exp=%b", obs, expv(1, 0, 0, 0, 0));
      end
   endtask

   task automatic test_max();
      apply(pack(255, 255, 0, 0), 1'b1, 1'b0);
      total++;
      if (obs !== expv(1, 1, 1, 0, 1)) begin
         bad++;
         $display("FAIL max_grad got=%b exp=%b", obs, expv(1, 1, 1, 0, 1));
      end
      apply(pack(0, 0, 255, 255), 1'b1, 1'b0);
      total++;
      if (obs !== expv(1, 1, 1, 1, 0)) begin
         bad++;
         $display("FAIL max_grad_neg got=%b exp=%b", obs, expv(1, 1, 1, 1, 0));
      end
   endtask

   task automatic test_threshold();
      // {up,right,down,left, expected thdx,thdy,sgnx,sgny}
      int vec [8][8] = '{
         '{0,  31, 0,  0,  0, 0, 0, 0},
         '{0,  32, 0,  0,  1, 0, 0, 0},
         '{0,  0,  0,  40, 1, 0, 1, 0},
         '{0,  0,  0,  31, 0, 0, 1, 0},
         '{0,  0,  0,  32, 1, 0, 1, 0},
         '{50, 0,  19, 0,  0, 0, 0, 1},
         '{50, 0,  18, 0,  0, 1, 0, 1},
         '{10, 70, 42, 38, 1, 1, 0, 0}
      };
      for (int i = 0; i < 8; i++) begin
         apply(pack(vec[i][0], vec[i][1], vec[i][2], vec[i][3]), 1'b1, 1'b0);
         total++;
         if (obs !== expv(1, vec[i][4][0], vec[i][5][0], vec[i][6][0], vec[i][7][0])) begin
            bad++;
            $display("FAIL threshold v=%0d got=%b exp=%b", i, obs,
                     expv(1, vec[i][4][0], vec[i][5][0], vec[i][6][0], vec[i][7][0]));
         end
      end
   endtask

   task automatic test_reset_hold();
      apply(pack(255, 255, 0, 0), 1'b1, 1'b1);
      total++;
      if (obs !== expv(0, 0, 0, 0, 0)) begin
         bad++;
         $display("FAIL reset_discard got=%b exp=%b", obs, expv(0, 0, 0, 0, 0));
      end
      apply(pack(255, 255, 0, 0), 1'b0, 1'b0);
      total++;
      if (obs !== expv(0, 0, 0, 0, 0)) begin
         bad++;
         $display("FAIL hold_after_reset got=%b exp=%b", obs, expv(0, 0, 0, 0, 0));
      end
      apply(pack(255, 255, 0, 0), 1'b1, 1'b0);
      total++;
      if (obs !== expv(1, 1, 1, 0, 1)) begin
         bad++;
         $display("FAIL first_after_reset got=%b exp=%b", obs, expv(1, 1, 1, 0, 1));
      end
      apply(32'h0, 1'b0, 1'b0);
      total++;
      if (obs !== expv(0, 1, 1, 0, 1)) begin
         bad++;
         $display("FAIL hold_flags got=%b exp=%b", obs, expv(0, 1, 1, 0, 1));
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] blk;
      int dx, dy;
      logic [OW-1:0] e;
      for (int i = 0; i < 100; i++) begin
         blk = $urandom;
         if (i % 4 == 0) blk[7:0] = blk[23:16] - 8'(31 + (i % 3));
         dx = int'(blk[23:16]) - int'(blk[7:0]);
         dy = int'(blk[15:8]) - int'(blk[31:24]);
         e = expv(1, (dx >= 32) || (dx <= -32), (dy >= 32) || (dy <= -32), dx < 0, dy < 0);
         apply(blk, 1'b1, 1'b0);
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL b2b i=%0d blk=%h got=%b exp=%b", i, blk, obs, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_small();
      test_flat();
      test_max();
      test_threshold();
      test_reset_hold();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
